regfile_param: RTL and testbench

- Parametrised successor to the processor's fixed 4x8 register file: configurable data width and depth, two combinational read ports, one write port.
- Adds asynchronous reset-to-zero, optional hardwired-zero register 0, optional write-to-read bypass, and a sequenced bulk-clear operation with a busy/done handshake.
- Sits between the instruction decoder and the ALU in the microprocessor datapath.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_if.sv | 23 ++
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_param.sv | 60 ++++++
 tb/tb_regfile_param.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// The state encoding is fixed here so the array and the clear sequencer agree on it.
package regfile_pkg;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
endpackage

// File: rtl/regfile_if.sv
// Decoder-side bus into the register file: two read ports, one write port, bulk clear.
interface regfile_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF
);
  import regfile_pkg::*;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] writeData;
  logic              RegWrite;
  logic              clr;
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;
  logic              busy;
  logic              done;
  logic              wr_drop;

  modport master (output rs, rt, rd, writeData, RegWrite, clr,
                  input  rsData, rtData, busy, done, wr_drop);
  modport slave  (input  rs, rt, rd, writeData, RegWrite, clr,
                  output rsData, rtData, busy, done, wr_drop);
endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every register index once, one per cycle,
// and reports busy/done plus writes discarded while sweeping.
module regfile_clear_fsm import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              RegWrite,
  output logic              busy,
  output logic              done,
  output logic              wr_drop,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  state_t          state, stateNext;
  logic [ADDR_W:0] cnt, cntNext;
  logic            doneNext, dropNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      done    <= doneNext;
      wr_drop <= dropNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    doneNext  = 1'b0;
    dropNext  = 1'b0;
    case (state)
      IDLE: if (clr) begin
        stateNext = SWEEP;
        cntNext   = '0;
      end
      SWEEP: begin
        // clr is deliberately not looked at here: a running sweep is never restarted
        cntNext  = cnt + 1'b1;
        dropNext = RegWrite;
        if (cnt == LAST) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy     = (state == SWEEP);
  assign clr_en   = busy;
  assign clr_addr = cnt[ADDR_W-1:0];
endmodule

// File: rtl/regfile_param.sv
// Parametrised register file between decoder and ALU: combinational dual read,
// single write, optional hardwired zero register and write-to-read forwarding.
module regfile_param import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         busy, clrEn, weff;
  logic [ADDR_W-1:0]            clrAddr;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) uClr (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .RegWrite (bus.RegWrite),
    .busy     (busy),
    .done     (bus.done),
    .wr_drop  (bus.wr_drop),
    .clr_en   (clrEn),
    .clr_addr (clrAddr)
  );

  assign bus.busy = busy;

  // rst in weff keeps the forwarding path from leaking writeData while in reset
  assign weff = bus.RegWrite && !busy && !rst && !(ZERO_REG && bus.rd == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      if (weff)  regs[bus.rd]  <= bus.writeData;
      if (clrEn) regs[clrAddr] <= '0;
    end
  end

  always_comb begin
    bus.rsData = regs[bus.rs];
    if (ZERO_REG && bus.rs == '0)
      bus.rsData = '0;
    else if (BYPASS && weff && bus.rd == bus.rs)
      bus.rsData = bus.writeData;
  end

  always_comb begin
    bus.rtData = regs[bus.rt];
    if (ZERO_REG && bus.rt == '0)
      bus.rtData = '0;
    else if (BYPASS && weff && bus.rd == bus.rt)
      bus.rtData = bus.writeData;
  end
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and
// are compared every cycle against an array-based reference of the register file.
module tb_regfile_param;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rs = '0, rt = '0, rd = '0;
  logic [DW-1:0] wd = '0;
  logic          we = 1'b0, clr = 1'b0;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) ifA ();
  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) ifB ();
  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) ifC ();

  assign ifA.rs = rs;  assign ifA.rt = rt;  assign ifA.rd = rd;
  assign ifA.writeData = wd;  assign ifA.RegWrite = we;  assign ifA.clr = clr;
  assign ifB.rs = rs;  assign ifB.rt = rt;  assign ifB.rd = rd;
  assign ifB.writeData = wd;  assign ifB.RegWrite = we;  assign ifB.clr = clr;
  assign ifC.rs = rs;  assign ifC.rt = rt;  assign ifC.rd = rd;
  assign ifC.writeData = wd;  assign ifC.RegWrite = we;  assign ifC.clr = clr;

  // cfg0: bypass on; cfg1: bypass off; cfg2: zero register + bypass
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b1))
    dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0))
    dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  logic [DW-1:0] rsD [3];
  logic [DW-1:0] rtD [3];
  logic          busyD [3], doneD [3], dropD [3];
  assign rsD[0] = ifA.rsData;  assign rtD[0] = ifA.rtData;
  assign rsD[1] = ifB.rsData;  assign rtD[1] = ifB.rtData;
  assign rsD[2] = ifC.rsData;  assign rtD[2] = ifC.rtData;
  assign busyD[0] = ifA.busy;  assign doneD[0] = ifA.done;  assign dropD[0] = ifA.wr_drop;
  assign busyD[1] = ifB.busy;  assign doneD[1] = ifB.done;  assign dropD[1] = ifB.wr_drop;
  assign busyD[2] = ifC.busy;  assign doneD[2] = ifC.done;  assign dropD[2] = ifC.wr_drop;

  // Reference: register contents per config, plus number of sweep edges still to come
  int mem [3][DEPTH];
  int sweepLeft = 0;
  bit expDone = 1'b0, expDrop = 1'b0;
  int vectors = 0, miscompares = 0;

  function automatic bit zr(int k); return k == 2; endfunction
  function automatic bit bp(int k); return k != 1; endfunction

  function automatic bit writeOk(int k);
    return we && !rst && sweepLeft == 0 && !(zr(k) && rd == 0);
  endfunction

  function automatic logic [DW-1:0] expRead(int k, logic [AW-1:0] a);
    if (rst) return '0;
    if (zr(k) && a == 0) return '0;
    if (bp(k) && writeOk(k) && rd == a) return wd;
    return DW'(mem[k][a]);
  endfunction

  task automatic check(string tag, int k, logic [DW-1:0] got, logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cfg%0d observed=%h expected=%h t=%0t", tag, k, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      check("rsData",  k, rsD[k],             expRead(k, rs));
      check("rtData",  k, rtD[k],             expRead(k, rt));
      check("busy",    k, DW'(busyD[k]),      DW'(sweepLeft > 0));
      check("done",    k, DW'(doneD[k]),      DW'(expDone));
      check("wr_drop", k, DW'(dropD[k]),      DW'(expDrop));
    end
  endtask

  task automatic modelEdge();
    bit wasSweep;
    wasSweep = sweepLeft > 0;
    expDone  = 1'b0;
    expDrop  = 1'b0;
    if (wasSweep) begin
      for (int k = 0; k < 3; k++) mem[k][DEPTH - sweepLeft] = 0;
      sweepLeft--;
      expDone = (sweepLeft == 0);
      expDrop = we;
    end else begin
      for (int k = 0; k < 3; k++) if (writeOk(k)) mem[k][rd] = int'(wd);
      if (clr) sweepLeft = DEPTH;
    end
  endtask

  // Called at posedge+1: apply inputs, check mid-cycle, then advance one edge
  task automatic cycle(input logic [AW-1:0] s, t, d, input logic [DW-1:0] w,
                       input logic e, c);
    rs = s; rt = t; rd = d; wd = w; we = e; clr = c;
    #3 checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) for (int a = 0; a < DEPTH; a++) mem[k][a] = 0;
    sweepLeft = 0;
    expDone   = 1'b0;
    expDrop   = 1'b0;
    #2 checkAll();
    @(posedge clk);
    #1 checkAll();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // reset, then read back zeros
    doReset();
    cycle(2'd1, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0);

    // plain writes and reads
    cycle(2'd0, 2'd0, 2'd2, 8'hA5, 1'b1, 1'b0);
    cycle(2'd0, 2'd0, 2'd1, 8'h3C, 1'b1, 1'b0);
    cycle(2'd2, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0);

    // forwarding on a same-cycle write to a read address
    cycle(2'd0, 2'd0, 2'd3, 8'h11, 1'b1, 1'b0);
    cycle(2'd3, 2'd3, 2'd3, 8'h77, 1'b1, 1'b0);
    cycle(2'd3, 2'd2, 2'd0, 8'h00, 1'b0, 1'b0);

    // write to register 0
    cycle(2'd0, 2'd0, 2'd0, 8'hFF, 1'b1, 1'b0);
    cycle(2'd0, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0);

    // fill 1..4, clear with a write at E0 and writes held through the sweep
    for (int i = 0; i < DEPTH; i++)
      cycle(AW'(i), AW'(i), AW'(i), DW'(i + 1), 1'b1, 1'b0);
    cycle(2'd1, 2'd2, 2'd1, 8'hEE, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(AW'(i), AW'(3 - i), 2'd1, 8'hEE, 1'b1, 1'b1);
    cycle(2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0);
    cycle(2'd2, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0);

    // reset in the middle of a sweep, then a full sweep afterwards
    for (int i = 0; i < DEPTH; i++)
      cycle(AW'(i), AW'(i), AW'(i), DW'(8'h50 + i), 1'b1, 1'b0);
    cycle(2'd1, 2'd3, 2'd0, 8'h00, 1'b0, 1'b1);
    cycle(2'd1, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0);
    cycle(2'd1, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0);
    doReset();
    cycle(2'd2, 2'd3, 2'd2, 8'h99, 1'b1, 1'b0);
    cycle(2'd2, 2'd3, 2'd0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(AW'(i), 2'd2, 2'd0, 8'h00, 1'b0, 1'b0);

    // random traffic with occasional clears
    for (int n = 0; n < 300; n++)
      cycle(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
            AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
